// File: rtl/crypto_bus_initiator.sv
// crypto_bus_initiator
//
// Host-side initiator for the crypto-core byte bus. Accepts one command, holds the
// command sideband stable for the whole transaction, passes payload bytes from the
// host to the core, passes result bytes from the core back to the host, and finishes
// on the core's ack. An inactivity timer aborts a stalled transaction.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_*                           command handshake and fields
//   host_in_*                       payload bytes from the host
//   host_out_*                      result bytes to the host
//   opcode/source_id/dest_id/
//   encdec/addr                     registered sideband to the core
//   data_in/valid_in/ready_in       byte stream to the core
//   data_out/data_valid/data_ready  byte stream from the core
//   ack_valid/ack_ready             completion handshake from the core
//   busy, done, err                 status: not idle, completion pulse, abort pulse
module crypto_bus_initiator #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = 6,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opcode,
    input  logic [1:0]       cmd_source_id,
    input  logic [1:0]       cmd_dest_id,
    input  logic             cmd_encdec,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_tx_len,
    input  logic [LEN_W-1:0] cmd_rx_len,
    input  logic [7:0]       host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [7:0]       host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_ready,
    output logic [1:0]       opcode,
    output logic [1:0]       source_id,
    output logic [1:0]       dest_id,
    output logic             encdec,
    output logic [23:0]      addr,
    output logic [7:0]       data_in,
    output logic             valid_in,
    input  logic             ready_in,
    input  logic [7:0]       data_out,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             ack_valid,
    output logic             ack_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
    // The abort fires on the edge that closes the TIMEOUT-th quiet cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StRecv, StAck} state_e;

    state_e state_q, state_d;
    logic [LEN_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic [1:0]  opcode_q, source_id_q, dest_id_q;
    logic        encdec_q;
    logic [23:0] addr_q;
    logic        cmd_hs, tx_hs, rx_hs;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN_V) ? MAX_LEN_V : len;
    endfunction

    // Handshake outputs: pass-through inside the owning state, zero elsewhere.
    // Streams are also closed once their count is exhausted so a zero-length
    // SEND cannot move a byte.
    always_comb begin
        cmd_ready      = (state_q == StIdle);
        busy           = (state_q != StIdle);
        data_in        = '0;
        valid_in       = 1'b0;
        host_in_ready  = 1'b0;
        host_out_data  = '0;
        host_out_valid = 1'b0;
        data_ready     = 1'b0;
        ack_ready      = 1'b0;
        case (state_q)
            StSend: begin
                if (tx_cnt_q != '0) begin
                    data_in       = host_in_data;
                    valid_in      = host_in_valid;
                    host_in_ready = ready_in;
                end
            end
            StRecv: begin
                if (rx_cnt_q != '0) begin
                    host_out_data  = data_out;
                    host_out_valid = data_valid;
                    data_ready     = host_out_ready;
                end
            end
            StAck:   ack_ready = 1'b1;
            default: ;
        endcase
    end

    assign cmd_hs = cmd_valid & cmd_ready;
    assign tx_hs  = valid_in & host_in_ready;
    assign rx_hs  = host_out_valid & data_ready;

    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    tx_cnt_d = clamp_len(cmd_tx_len);
                    rx_cnt_d = clamp_len(cmd_rx_len);
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (tx_hs) begin
                    tx_cnt_d = tx_cnt_q - ONE_LEN;
                end
                if ((tx_cnt_q == '0) || (tx_hs && (tx_cnt_q == ONE_LEN))) begin
                    state_d = (rx_cnt_q != '0) ? StRecv : StAck;
                end
            end
            StRecv: begin
                if (rx_hs) begin
                    rx_cnt_d = rx_cnt_q - ONE_LEN;
                end
                if ((rx_cnt_q == '0) || (rx_hs && (rx_cnt_q == ONE_LEN))) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (ack_valid) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Any handshake or state change restarts the inactivity window, and that
        // takes priority over an abort falling in the same cycle.
        if (state_q != StIdle) begin
            if ((state_d != state_q) || tx_hs || rx_hs) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d = StIdle;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            opcode_q    <= '0;
            source_id_q <= '0;
            dest_id_q   <= '0;
            encdec_q    <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q  <= state_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            err_q    <= err_d;
            // Sideband only loads on acceptance, so it also persists through IDLE.
            if (cmd_hs) begin
                opcode_q    <= cmd_opcode;
                source_id_q <= cmd_source_id;
                dest_id_q   <= cmd_dest_id;
                encdec_q    <= cmd_encdec;
                addr_q      <= cmd_addr;
            end
        end
    end

    assign opcode    = opcode_q;
    assign source_id = source_id_q;
    assign dest_id   = dest_id_q;
    assign encdec    = encdec_q;
    assign addr      = addr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_crypto_bus_initiator.sv
// tb_crypto_bus_initiator
//
// Directed-plus-random bench for crypto_bus_initiator. Expected byte streams, counts
// and cycle positions come from the transaction rules (bytes in order, one per cycle
// when unstalled, SEND at least one cycle, ACK after the streams).
module tb_crypto_bus_initiator;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned LEN_W   = 6;
    localparam int unsigned TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_opcode, cmd_source_id, cmd_dest_id;
    logic             cmd_encdec;
    logic [23:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_tx_len, cmd_rx_len;
    logic [7:0]       host_in_data;
    logic             host_in_valid, host_in_ready;
    logic [7:0]       host_out_data;
    logic             host_out_valid, host_out_ready;
    logic [1:0]       opcode, source_id, dest_id;
    logic             encdec;
    logic [23:0]      addr;
    logic [7:0]       data_in;
    logic             valid_in, ready_in;
    logic [7:0]       data_out;
    logic             data_valid, data_ready;
    logic             ack_valid, ack_ready;
    logic             busy, done, err;

    always #5 clk = ~clk;

    crypto_bus_initiator #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_source_id (cmd_source_id),
        .cmd_dest_id   (cmd_dest_id),
        .cmd_encdec    (cmd_encdec),
        .cmd_addr      (cmd_addr),
        .cmd_tx_len    (cmd_tx_len),
        .cmd_rx_len    (cmd_rx_len),
        .host_in_data  (host_in_data),
        .host_in_valid (host_in_valid),
        .host_in_ready (host_in_ready),
        .host_out_data (host_out_data),
        .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready),
        .opcode        (opcode),
        .source_id     (source_id),
        .dest_id       (dest_id),
        .encdec        (encdec),
        .addr          (addr),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .ack_valid     (ack_valid),
        .ack_ready     (ack_ready),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_op, exp_src, exp_dst;
    logic        exp_enc;
    logic [23:0] exp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit sideband_ok();
        return (opcode === exp_op) && (source_id === exp_src) && (dest_id === exp_dst) &&
               (encdec === exp_enc) && (addr === exp_addr);
    endfunction

    // Presents a command from IDLE; it must be taken in the first cycle offered.
    task automatic issue_cmd(input logic [1:0] op, input logic [23:0] a, input int tx,
                             input int rx);
        int waited = 0;
        exp_op   = op;
        exp_src  = 2'($urandom);
        exp_dst  = 2'($urandom);
        exp_enc  = 1'($urandom);
        exp_addr = a;
        cmd_opcode    = exp_op;
        cmd_source_id = exp_src;
        cmd_dest_id   = exp_dst;
        cmd_encdec    = exp_enc;
        cmd_addr      = exp_addr;
        cmd_tx_len    = LEN_W'(tx);
        cmd_rx_len    = LEN_W'(rx);
        cmd_valid     = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_accept_wait", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("done_clear_after_accept", 32'(done), 32'd0);
        check("sideband_after_accept", 32'(sideband_ok()), 32'd1);
    endtask

    // Runs one transaction from the first SEND cycle to the cycle after the ack.
    // ack_wait < 0 holds ack_valid high throughout; otherwise ack_valid rises after
    // ack_ready has been seen for ack_wait cycles.
    task automatic run_txn(input int tx_n, input int rx_n, input bit stall, input int ack_wait);
        logic [7:0] tx_bytes[$];
        logic [7:0] rx_bytes[$];
        logic [7:0] core_got[$];
        logic [7:0] host_got[$];
        int tx_i = 0, rx_i = 0, cyc = 0, ack_seen = 0, first_ack = 0, hs_cyc = 0;
        int tx_first = 0, tx_last = 0, rx_first = 0, rx_last = 0;
        int run_r = 0, run_h = 0, bad = 0;
        bit sb_ok = 1'b1, gate_ok = 1'b1, busy_ok = 1'b1, fin = 1'b0;
        for (int i = 0; i < tx_n; i++) tx_bytes.push_back(8'($urandom));
        for (int i = 0; i < rx_n; i++) rx_bytes.push_back(stall ? 8'($urandom) : 8'(i));
        while (!fin && cyc < 400) begin
            cyc++;
            host_in_valid = (tx_i < tx_n);
            host_in_data  = host_in_valid ? tx_bytes[tx_i] : 8'h00;
            data_valid    = (rx_i < rx_n);
            data_out      = data_valid ? rx_bytes[rx_i] : 8'h00;
            // Stalls never run long enough to trip the inactivity timer.
            ready_in       = !stall || run_r >= 3 || ($urandom_range(0, 1) == 1);
            host_out_ready = !stall || run_h >= 3 || ($urandom_range(0, 1) == 1);
            run_r = ready_in ? 0 : run_r + 1;
            run_h = host_out_ready ? 0 : run_h + 1;
            ack_valid = (ack_wait < 0) || (ack_seen >= ack_wait);
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (!sideband_ok()) sb_ok = 1'b0;
            if (ack_ready && (tx_i < tx_n || rx_i < rx_n)) gate_ok = 1'b0;
            if ((valid_in || host_in_ready) && (host_out_valid || data_ready)) gate_ok = 1'b0;
            if (valid_in && host_in_ready) begin
                core_got.push_back(data_in);
                tx_i++;
                if (tx_i == 1) tx_first = cyc;
                tx_last = cyc;
            end
            if (host_out_valid && data_ready) begin
                host_got.push_back(host_out_data);
                rx_i++;
                if (rx_i == 1) rx_first = cyc;
                rx_last = cyc;
            end
            if (ack_ready) begin
                ack_seen++;
                if (ack_seen == 1) first_ack = cyc;
                if (ack_valid) begin
                    fin    = 1'b1;
                    hs_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
        end
        check("ack_reached", 32'(fin), 32'd1);
        check("done_pulse", 32'(done), 32'd1);
        check("idle_after_ack", 32'(busy), 32'd0);
        check("cmd_ready_after_ack", 32'(cmd_ready), 32'd1);
        ack_valid     = 1'b0;
        host_in_valid = 1'b0;
        data_valid    = 1'b0;
        check("tx_count", 32'(core_got.size()), 32'(tx_n));
        check("rx_count", 32'(host_got.size()), 32'(rx_n));
        for (int i = 0; i < tx_n && i < core_got.size(); i++)
            if (core_got[i] !== tx_bytes[i]) bad++;
        for (int i = 0; i < rx_n && i < host_got.size(); i++)
            if (host_got[i] !== rx_bytes[i]) bad++;
        check("byte_order", 32'(bad), 32'd0);
        check("sideband_stable", 32'(sb_ok), 32'd1);
        check("stream_gating", 32'(gate_ok), 32'd1);
        check("busy_during_txn", 32'(busy_ok), 32'd1);
        check("ack_hs_cycle", 32'(hs_cyc), 32'(first_ack + ((ack_wait < 0) ? 0 : ack_wait)));
        if (!stall) begin
            check("first_ack_cycle", 32'(first_ack), 32'(((tx_n > 0) ? tx_n : 1) + rx_n + 1));
            if (tx_n > 0) begin
                check("tx_first", 32'(tx_first), 32'd1);
                check("tx_span", 32'(tx_last - tx_first), 32'(tx_n - 1));
            end
            if (rx_n > 0) begin
                check("rx_first", 32'(rx_first), 32'(((tx_n > 0) ? tx_n : 1) + 1));
                check("rx_span", 32'(rx_last - rx_first), 32'(rx_n - 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int err_cyc, err_cnt, busy_cnt;
        bit err_idle;
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_opcode     = '0;
        cmd_source_id  = '0;
        cmd_dest_id    = '0;
        cmd_encdec     = 1'b0;
        cmd_addr       = '0;
        cmd_tx_len     = '0;
        cmd_rx_len     = '0;
        host_in_data   = '0;
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        ready_in       = 1'b0;
        data_out       = '0;
        data_valid     = 1'b0;
        ack_valid      = 1'b0;
        exp_op = '0; exp_src = '0; exp_dst = '0; exp_enc = 1'b0; exp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ack_ready", 32'(ack_ready), 32'd0);
        check("rst_sideband", 32'(sideband_ok()), 32'd1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full 16/16 transaction, core always ready, ack already waiting.
        issue_cmd(2'b01, 24'hABCDEF, 16, 16);
        check("addr_abcdef", 32'(addr), 32'hABCDEF);
        run_txn(16, 16, 1'b0, 0);

        // Zero-length command issued back to back; ack arrives 5 cycles into ACK.
        issue_cmd(2'($urandom), 24'($urandom), 0, 0);
        run_txn(0, 0, 1'b0, 5);

        // Random stalls on both streams.
        issue_cmd(2'($urandom), 24'($urandom), 4, 2);
        run_txn(4, 2, 1'b1, 0);

        // ack_valid held from the start must wait for ACK.
        issue_cmd(2'($urandom), 24'($urandom), 3, 2);
        run_txn(3, 2, 1'b0, -1);

        // Over-long lengths are clamped to MAX_LEN.
        issue_cmd(2'($urandom), 24'($urandom), 40, 33);
        run_txn(MAX_LEN, MAX_LEN, 1'b0, 0);

        // Asynchronous reset after 3 of 16 payload bytes.
        issue_cmd(2'b11, 24'h123456, 16, 4);
        hs = 0;
        host_in_valid = 1'b1;
        ready_in      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_in_data = 8'($urandom);
            @(negedge clk);
            if (valid_in && host_in_ready) hs++;
            @(posedge clk);
            #1;
        end
        check("pre_reset_bytes", 32'(hs), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_valid_in", 32'(valid_in), 32'd0);
        check("midrst_host_in_ready", 32'(host_in_ready), 32'd0);
        check("midrst_opcode", 32'(opcode), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        host_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Core never ready: abort after TIMEOUT quiet cycles.
        issue_cmd(2'($urandom), 24'($urandom), 4, 0);
        host_in_valid = 1'b1;
        host_in_data  = 8'h5A;
        ready_in      = 1'b0;
        hs = 0; err_cyc = 0; err_cnt = 0; busy_cnt = 0; err_idle = 1'b0;
        for (int c = 1; c <= int'(TIMEOUT) + 4; c++) begin
            @(negedge clk);
            if (valid_in && host_in_ready) hs++;
            if (busy) busy_cnt++;
            if (err) begin
                err_cnt++;
                if (err_cyc == 0) err_cyc = c;
                if (!busy && cmd_ready && !valid_in) err_idle = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        host_in_valid = 1'b0;
        ready_in      = 1'b1;
        check("tmo_no_bytes", 32'(hs), 32'd0);
        check("tmo_busy_cycles", 32'(busy_cnt), 32'(TIMEOUT));
        check("tmo_err_cycle", 32'(err_cyc), 32'(TIMEOUT + 1));
        check("tmo_err_width", 32'(err_cnt), 32'd1);
        check("tmo_err_with_idle", 32'(err_idle), 32'd1);

        // Normal command after the abort.
        issue_cmd(2'($urandom), 24'($urandom), 2, 1);
        run_txn(2, 1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
